multicycle_ctrl: RTL and testbench

- Control FSM that sequences the multicycle RV32I datapath (PC/OldPC/IR registers, A/WriteData/ALUOut/Data registers, shared ALU, single memory port).
- Decodes the latched instruction and drives every mux select, write enable and ALU operation, one state per cycle.
- Stalls on a simple request/ready memory handshake.
- Flags unsupported opcodes and halts.

---
 rtl/multicycle_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle RV32I datapath: one state per cycle, drives all
// mux selects, write enables and the ALU operation; stalls on mem_ready, traps on bad opcodes.
module multicycle_ctrl #(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        Zero,
  input  logic        cout,
  input  logic        overflow,
  input  logic        sign,
  input  logic        mem_ready,
  output logic [3:0]  ALUControl,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic        AdrSrc,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        mem_req,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR1, S_JALR2, S_LUI, S_AUIPC, S_TRAP
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
                         ALU_OR  = 4'b0011, ALU_XOR = 4'b0100, ALU_SLL = 4'b0101,
                         ALU_SRL = 4'b0110, ALU_SRA = 4'b0111, ALU_SLT = 4'b1000,
                         ALU_SLTU = 4'b1001;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  state_t      r_state;
  logic        r_illegal;
  logic        w_ready;
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_b30;
  logic        w_taken;
  logic        w_bad_br;
  logic        w_irwrite, w_pcwrite, w_regwrite, w_memwrite, w_mem_req;
  logic        w_unused_bits;

  assign w_ready       = USE_MEM_READY ? mem_ready : 1'b1;
  assign w_opcode      = instr[6:0];
  assign w_funct3      = instr[14:12];
  assign w_b30         = instr[30];
  assign w_bad_br      = (w_funct3[2:1] == 2'b01);
  assign w_unused_bits = &{instr[31], instr[29:15], instr[11:7]};

  function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic alt_sub,
                                        input logic alt_sra);
    case (f3)
      3'b000:  alu_fn = alt_sub ? ALU_SUB : ALU_ADD;
      3'b001:  alu_fn = ALU_SLL;
      3'b010:  alu_fn = ALU_SLT;
      3'b011:  alu_fn = ALU_SLTU;
      3'b100:  alu_fn = ALU_XOR;
      3'b101:  alu_fn = alt_sra ? ALU_SRA : ALU_SRL;
      3'b110:  alu_fn = ALU_OR;
      default: alu_fn = ALU_AND;
    endcase
  endfunction

  always_comb begin
    case (w_funct3)
      3'b000:  w_taken = Zero;
      3'b001:  w_taken = ~Zero;
      3'b100:  w_taken = sign ^ overflow;
      3'b101:  w_taken = ~(sign ^ overflow);
      3'b110:  w_taken = ~cout;
      3'b111:  w_taken = cout;
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH:  if (w_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (w_opcode)
            OP_LOAD, OP_STORE: r_state <= S_MEMADR;
            OP_R:     r_state <= S_EXECR;
            OP_I:     r_state <= S_EXECI;
            OP_BR:    r_state <= S_BRANCH;
            OP_JAL:   r_state <= S_JAL;
            OP_JALR:  r_state <= S_JALR1;
            OP_LUI:   r_state <= S_LUI;
            OP_AUIPC: r_state <= S_AUIPC;
            default: begin
              r_state   <= S_TRAP;
              r_illegal <= 1'b1;
            end
          endcase
        end
        S_MEMADR:   r_state <= (w_opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (w_ready) r_state <= S_MEMWB;
        S_MEMWRITE: if (w_ready) r_state <= S_FETCH;
        S_MEMWB, S_ALUWB, S_LUI: r_state <= S_FETCH;
        S_EXECR, S_EXECI, S_JAL, S_JALR2, S_AUIPC: r_state <= S_ALUWB;
        S_JALR1:    r_state <= S_JALR2;
        S_BRANCH: begin
          r_state <= S_FETCH;
          if (w_bad_br) r_illegal <= 1'b1;
        end
        default:    r_state <= S_TRAP;
      endcase
    end
  end

  always_comb begin
    ALUControl = ALU_ADD;
    ResultSrc  = '0;
    ALUSrcA    = '0;
    ALUSrcB    = '0;
    AdrSrc     = 1'b0;
    w_irwrite  = 1'b0;
    w_pcwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_memwrite = 1'b0;
    w_mem_req  = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        ALUSrcB   = 2'd2;
        ResultSrc = 2'd2;
        w_irwrite = w_ready;
        w_pcwrite = w_ready;
      end
      S_DECODE, S_AUIPC: begin
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd1;
      end
      S_MEMADR, S_JALR1: begin
        ALUSrcA = 2'd2;
        ALUSrcB = 2'd1;
      end
      S_MEMREAD: begin
        AdrSrc    = 1'b1;
        w_mem_req = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        w_mem_req  = 1'b1;
        w_memwrite = w_ready;
      end
      S_MEMWB: begin
        ResultSrc  = 2'd1;
        w_regwrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA    = 2'd2;
        ALUControl = alu_fn(w_funct3, w_b30, w_b30);
      end
      S_EXECI: begin
        ALUSrcA    = 2'd2;
        ALUSrcB    = 2'd1;
        ALUControl = alu_fn(w_funct3, 1'b0, w_b30);
      end
      S_ALUWB: w_regwrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA    = 2'd2;
        ALUControl = ALU_SUB;
        w_pcwrite  = w_taken;
      end
      // PC takes the current Result while ALUOut captures OldPC+4 for the link write
      S_JAL, S_JALR2: begin
        ALUSrcA   = 2'd1;
        ALUSrcB   = 2'd2;
        w_pcwrite = 1'b1;
      end
      S_LUI: begin
        ResultSrc  = 2'd3;
        w_regwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign IRWrite  = w_irwrite  & reset;
  assign PCWrite  = w_pcwrite  & reset;
  assign RegWrite = w_regwrite & reset;
  assign MemWrite = w_memwrite & reset;
  assign mem_req  = w_mem_req  & reset;
  assign illegal  = r_illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed cycle-exact sequences, then random instructions
// checked per instruction against counts derived from the instruction class.
module tb_multicycle_ctrl;

  logic        clk = 1'b0, reset = 1'b0;
  logic [31:0] instr = '0;
  logic        Zero = 1'b0, cout = 1'b0, overflow = 1'b0, sign = 1'b0, mem_ready = 1'b0;
  logic [3:0]  ALUControl;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
  logic        AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, mem_req, illegal;

  int unsigned n_tests = 0, n_fail = 0;
  logic        sticky = 1'b0;

  multicycle_ctrl #(.USE_MEM_READY(1'b1)) dut (
    .clk(clk), .reset(reset), .instr(instr), .Zero(Zero), .cout(cout),
    .overflow(overflow), .sign(sign), .mem_ready(mem_ready),
    .ALUControl(ALUControl), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .mem_req(mem_req), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] mk(input logic [3:0] alu, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic adr, input logic ir, input logic pc,
                                     input logic rw, input logic mw, input logic req,
                                     input logic ill);
    return {alu, rs, sa, sb, adr, ir, pc, rw, mw, req, ill};
  endfunction

  function automatic logic [16:0] snap();
    return {ALUControl, ResultSrc, ALUSrcA, ALUSrcB, AdrSrc, IRWrite, PCWrite,
            RegWrite, MemWrite, mem_req, illegal};
  endfunction

  function automatic logic [5:0] strobes();
    return {IRWrite, PCWrite, RegWrite, MemWrite, mem_req, illegal};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [31:0] ins, input logic rdy, input logic [16:0] exp,
                      input string tag);
    @(negedge clk);
    instr     = ins;
    mem_ready = rdy;
    #1;
    check(tag, 32'(snap()), 32'(exp));
  endtask

  // ALU operation named by the ISA for an R/I arithmetic instruction
  function automatic logic [3:0] exp_op(input logic [2:0] f3, input logic b30, input logic is_r);
    case (f3)
      3'd0: return (is_r && b30) ? 4'd1 : 4'd0;
      3'd1: return 4'd5;
      3'd2: return 4'd8;
      3'd3: return 4'd9;
      3'd4: return 4'd4;
      3'd5: return b30 ? 4'd7 : 4'd6;
      3'd6: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  task automatic run_rand(input int unsigned idx);
    int unsigned cls, wf, wd, cpi, ncyc, acc, wcnt, rw, mw, pcw, irw, acyc, e_pcw, e_acyc;
    logic [31:0] ins, a, b, diff;
    logic [3:0]  e_op, aop;
    logic [1:0]  e_sb, asb, e_rs, rsrc;
    logic        taken, bad, e_rw, e_mw, adr_mw, z, c, s, o;
    ins  = $urandom;
    cls  = $urandom_range(0, 8);
    wf   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
    wd   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
    a    = $urandom;
    b    = ($urandom_range(0, 3) == 0) ? a : $urandom;
    diff = a - b;
    z = (diff == 0); c = (a >= b); s = diff[31];
    o = (a[31] != b[31]) && (diff[31] != a[31]);
    taken = 1'b0; bad = 1'b0; e_op = 4'd0; e_sb = 2'd1; e_rs = 2'd0;
    e_rw = 1'b1; e_mw = 1'b0; e_pcw = 1; e_acyc = 1; cpi = 4;
    case (cls)
      0: begin
        ins[6:0] = 7'h33; ins[31:25] = ins[30] ? 7'h20 : 7'h00;
        e_op = exp_op(ins[14:12], ins[30], 1'b1); e_sb = 2'd0;
      end
      1: begin ins[6:0] = 7'h13; e_op = exp_op(ins[14:12], ins[30], 1'b0); end
      2: begin ins[6:0] = 7'h03; cpi = 5; e_rs = 2'd1; end
      3: begin ins[6:0] = 7'h23; e_rw = 1'b0; e_mw = 1'b1; end
      4: begin
        ins[6:0] = 7'h63; cpi = 3; e_op = 4'd1; e_sb = 2'd0; e_rw = 1'b0;
        case (ins[14:12])
          3'd0: taken = (a == b);
          3'd1: taken = (a != b);
          3'd4: taken = ($signed(a) < $signed(b));
          3'd5: taken = ($signed(a) >= $signed(b));
          3'd6: taken = (a < b);
          3'd7: taken = (a >= b);
          default: bad = 1'b1;
        endcase
        e_pcw = 1 + int'(taken);
      end
      5: begin ins[6:0] = 7'h6F; e_pcw = 2; e_acyc = 0; end
      6: begin ins[6:0] = 7'h67; cpi = 5; e_pcw = 2; end
      7: begin ins[6:0] = 7'h37; cpi = 3; e_rs = 2'd3; e_acyc = 0; end
      default: begin ins[6:0] = 7'h17; e_acyc = 0; end
    endcase
    ncyc = cpi + wf + ((cls == 2 || cls == 3) ? wd : 0);
    acc = 0; wcnt = 0; rw = 0; mw = 0; pcw = 0; irw = 0; acyc = 0;
    aop = '0; asb = '0; rsrc = '0; adr_mw = 1'b0;
    for (int unsigned cy = 0; cy < ncyc; cy++) begin
      @(negedge clk);
      if (cy == 0) begin
        instr = ins; Zero = z; cout = c; sign = s; overflow = o;
      end
      #1;
      if (mem_req) mem_ready = (wcnt == ((acc == 0) ? wf : (acc == 1) ? wd : 0));
      else         mem_ready = 1'($urandom_range(0, 1));
      #1;
      if (cy == 0) begin
        check($sformatf("r%0d_fetch", idx), {28'd0, mem_req, AdrSrc, ALUSrcB}, 32'hA);
        check($sformatf("r%0d_illegal", idx), 32'(illegal), 32'(sticky));
      end
      rw += RegWrite; mw += MemWrite; pcw += PCWrite; irw += IRWrite;
      if (RegWrite) rsrc = ResultSrc;
      if (MemWrite) adr_mw = AdrSrc;
      if (ALUSrcA == 2'd2) begin acyc++; aop = ALUControl; asb = ALUSrcB; end
      if (mem_req && mem_ready) begin acc++; wcnt = 0; end
      else if (mem_req) wcnt++;
    end
    check($sformatf("r%0d_irw", idx), irw, 1);
    check($sformatf("r%0d_rw", idx), rw, 32'(e_rw));
    check($sformatf("r%0d_mw", idx), mw, 32'(e_mw));
    check($sformatf("r%0d_pcw", idx), pcw, e_pcw);
    check($sformatf("r%0d_acyc", idx), acyc, e_acyc);
    if (e_acyc != 0) begin
      check($sformatf("r%0d_aluop", idx), 32'(aop), 32'(e_op));
      check($sformatf("r%0d_srcb", idx), 32'(asb), 32'(e_sb));
    end
    if (e_rw) check($sformatf("r%0d_rsrc", idx), 32'(rsrc), 32'(e_rs));
    if (e_mw) check($sformatf("r%0d_mwadr", idx), 32'(adr_mw), 32'd1);
    sticky = sticky | bad;
  endtask

  initial begin
    logic [16:0] vF, vD, vWB, vMR, vT;
    logic [31:0] SUB, LW, SW, BEQ, BLTU, BLT, JALR, BADBR, TRAP;
    SUB = 32'h40208033; LW = 32'h00012083; SW = 32'h00112023; BEQ = 32'h00000063;
    BLTU = 32'h00006063; BLT = 32'h00004063; JALR = 32'h00008067; BADBR = 32'h00002063;
    TRAP = 32'h0000007F;
    vF  = mk(4'd0, 2'd2, 2'd0, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    vD  = mk(4'd0, 2'd0, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vWB = mk(4'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    vMR = mk(4'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    vT  = mk(4'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    repeat (3) begin
      @(negedge clk); mem_ready = 1'b1; #1;
      check("rst_strobes", 32'(strobes()), 32'd0);
    end
    @(posedge clk); #1 reset = 1'b1;

    step(SUB, 1'b1, vF, "sub_fetch");
    step(SUB, 1'b1, vD, "sub_dec");
    step(SUB, 1'b1, mk(4'd1, 2'd0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "sub_exec");
    step(SUB, 1'b1, vWB, "sub_wb");

    step(LW, 1'b1, vF, "lw_fetch");
    step(LW, 1'b1, vD, "lw_dec");
    step(LW, 1'b1, mk(4'd0, 2'd0, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "lw_adr");
    step(LW, 1'b0, vMR, "lw_wait0");
    step(LW, 1'b0, vMR, "lw_wait1");
    step(LW, 1'b1, vMR, "lw_rd");
    step(LW, 1'b1, mk(4'd0, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), "lw_wb");

    Zero = 1'b1;
    step(BEQ, 1'b1, vF, "beq_fetch");
    step(BEQ, 1'b1, vD, "beq_dec");
    step(BEQ, 1'b1, mk(4'd1, 2'd0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "beq_br");
    Zero = 1'b0; cout = 1'b1;
    step(BLTU, 1'b1, vF, "bltu_fetch");
    step(BLTU, 1'b1, vD, "bltu_dec");
    step(BLTU, 1'b1, mk(4'd1, 2'd0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "bltu_br");
    cout = 1'b0; sign = 1'b1; overflow = 1'b1;
    step(BLT, 1'b1, vF, "blt_fetch");
    step(BLT, 1'b1, vD, "blt_dec");
    step(BLT, 1'b1, mk(4'd1, 2'd0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "blt_br");
    sign = 1'b0; overflow = 1'b0;

    step(JALR, 1'b1, vF, "jalr_fetch");
    step(JALR, 1'b1, vD, "jalr_dec");
    step(JALR, 1'b1, mk(4'd0, 2'd0, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "jalr_1");
    step(JALR, 1'b1, mk(4'd0, 2'd0, 2'd1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "jalr_2");
    step(JALR, 1'b1, vWB, "jalr_wb");

    step(BADBR, 1'b1, vF, "badbr_fetch");
    step(BADBR, 1'b1, vD, "badbr_dec");
    step(BADBR, 1'b1, mk(4'd1, 2'd0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "badbr_br");

    step(SW, 1'b1, vF | 17'd1, "badbr_sticky");
    step(SW, 1'b1, vD | 17'd1, "sw_dec");
    step(SW, 1'b1, mk(4'd0, 2'd0, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), "sw_adr");
    step(SW, 1'b0, vMR | 17'd1, "sw_wait");
    @(negedge clk); mem_ready = 1'b1; #1;
    check("sw_strobe", 32'(snap()), 32'(mk(4'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1)));
    #1 reset = 1'b0;
    #1 check("sw_abort", 32'(strobes()), 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    step(TRAP, 1'b1, vF, "trap_fetch");
    step(TRAP, 1'b1, vD, "trap_dec");
    repeat (4) step(TRAP, 1'b1, vT, "trap_hold");
    @(negedge clk); reset = 1'b0; #1;
    check("trap_rst", 32'(strobes()), 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    sticky = 1'b0;
    for (int unsigned i = 0; i < 300; i++) run_rand(i);
    @(negedge clk); #1;
    check("final_fetch", {29'd0, mem_req, ALUSrcB}, 32'h6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
